// File: rtl/bcd_time_counter_pkg.sv
// bcd_time_pkg: shared definitions for the BCD time counter.
//   BCD_W         width of one BCD digit
//   MODE_DEC/SEX  digit-limit modes (all 9s, or 9/5 alternating for mm:ss)
//   digit_limit() highest legal value of digit `index` in a given mode
//   div_of()      prescaler division ratio
//   bcd_next()    next value of one digit given load/inc/dec requests
package bcd_time_pkg;

  localparam int BCD_W    = 4;
  localparam int MODE_DEC = 0;
  localparam int MODE_SEX = 1;

  // In sexagesimal mode the odd digits are tens of seconds/minutes.
  function automatic logic [BCD_W-1:0] digit_limit(input int index, input int mode);
    logic [BCD_W-1:0] lim;
    lim = 4'd9;
    if (mode == MODE_SEX && (index % 2) == 1) lim = 4'd5;
    return lim;
  endfunction

  function automatic int div_of(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Load wins over counting; an out-of-range load digit is clamped to the limit.
  function automatic logic [BCD_W-1:0] bcd_next(
    input logic [BCD_W-1:0] d,
    input logic [BCD_W-1:0] lim,
    input logic             ld,
    input logic [BCD_W-1:0] ld_digit,
    input logic             inc,
    input logic             dec
  );
    logic [BCD_W-1:0] r;
    r = d;
    if (ld)       r = (ld_digit > lim) ? lim : ld_digit;
    else if (inc) r = (d == lim) ? '0 : d + 4'd1;
    else if (dec) r = (d == '0) ? lim : d - 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_counter_digit.sv
// bcd_digit: one up/down BCD digit that counts 0..LIMIT.
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   clr           synchronous clear to 0
//   inc, dec      step up / down this cycle (wrap at LIMIT / 0)
//   load          load load_digit (clamped to LIMIT); has priority over inc/dec
//   load_digit    value to load
//   digit         current digit value
//   at_limit      digit == LIMIT (carry condition for the next digit)
//   at_zero       digit == 0     (borrow condition for the next digit)
module bcd_digit
  import bcd_time_pkg::*;
#(
  parameter logic [BCD_W-1:0] LIMIT = 4'd9
)(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  output logic [BCD_W-1:0] digit,
  output logic             at_limit,
  output logic             at_zero
);

  always_ff @(posedge clk) begin
    if (!rstn)    digit <= '0;
    else if (clr) digit <= '0;
    else          digit <= bcd_next(digit, LIMIT, load, load_digit, inc, dec);
  end

  assign at_limit = (digit == LIMIT);
  assign at_zero  = (digit == '0);

endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: prescaled multi-digit BCD up/down counter
// (decimal or minutes:seconds), wrapping or saturating at full range.
// DIV = CLK_FREQ_HZ/TICK_HZ must be an integer >= 2.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   en          count enable (prescaler and digits hold while low)
//   up          direction, 1 = increment
//   clr         synchronous clear of prescaler and digits
//   load        load load_value (digits clamped to their limits)
//   load_value  BCD load value, digit 0 in [3:0]
//   count       current BCD value
//   tick        one-cycle pulse when the prescaler returns to 0
//   wrap        one-cycle pulse when the whole counter wraps
//   load_err    one-cycle pulse after a load with an out-of-range digit
// Optional (macro BCD_TIME_COUNTER_LAP_EN):
//   lap         capture the post-update count into lap_value
//   lap_value   captured count
//   lap_valid   set on capture, cleared by clr/reset
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int TICK_HZ     = 1,
  parameter int NUM_DIGITS  = 4,
  parameter int MODE        = MODE_DEC,
  parameter int WRAP        = 1
)(
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic                        up,
  input  logic                        clr,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
  output logic [BCD_W*NUM_DIGITS-1:0] count,
  output logic                        tick,
  output logic                        wrap,
  output logic                        load_err
`ifdef BCD_TIME_COUNTER_LAP_EN
  ,
  input  logic                        lap,
  output logic [BCD_W*NUM_DIGITS-1:0] lap_value,
  output logic                        lap_valid
`endif
);

  localparam int DIV = div_of(CLK_FREQ_HZ, TICK_HZ);
  localparam int PW  = $clog2(DIV);
  localparam logic WRAP_EN = (WRAP != 0);

  logic [PW-1:0]         presc;
  logic                  step;
  logic [NUM_DIGITS-1:0] at_lim, at_zero, inc, dec;
  logic [NUM_DIGITS:0]   lim_chain, zero_chain;
  logic                  full, hold, adv, wrap_next, over_any;

  // step is the cycle whose edge returns the prescaler to 0.
  assign step = en && (presc == PW'(DIV - 1));

  // Carry/borrow chain: digit i moves only when every lower digit is at its limit/zero.
  assign lim_chain[0]  = 1'b1;
  assign zero_chain[0] = 1'b1;

  assign full      = up ? lim_chain[NUM_DIGITS] : zero_chain[NUM_DIGITS];
  assign hold      = !WRAP_EN && full;
  assign adv       = step && !load && !hold;
  assign wrap_next = step && !load && full && WRAP_EN;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      assign lim_chain[g+1]  = lim_chain[g]  & at_lim[g];
      assign zero_chain[g+1] = zero_chain[g] & at_zero[g];
      assign inc[g] = adv &  up & lim_chain[g];
      assign dec[g] = adv & ~up & zero_chain[g];

      bcd_digit #(
        .LIMIT (digit_limit(g, MODE))
      ) u_digit (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .inc        (inc[g]),
        .dec        (dec[g]),
        .load       (load),
        .load_digit (load_value[g*BCD_W +: BCD_W]),
        .digit      (count[g*BCD_W +: BCD_W]),
        .at_limit   (at_lim[g]),
        .at_zero    (at_zero[g])
      );
    end
  endgenerate

  always_comb begin
    over_any = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (load_value[i*BCD_W +: BCD_W] > digit_limit(i, MODE)) over_any = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc    <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (clr) begin
      presc    <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      if (en) presc <= step ? '0 : presc + PW'(1);
      tick     <= step;
      wrap     <= wrap_next;
      load_err <= load && over_any;
    end
  end

`ifdef BCD_TIME_COUNTER_LAP_EN
  // Post-update count, so a lap on an update cycle sees the new value.
  logic [BCD_W*NUM_DIGITS-1:0] count_next;

  always_comb begin
    count_next = count;
    for (int i = 0; i < NUM_DIGITS; i++)
      count_next[i*BCD_W +: BCD_W] = bcd_next(count[i*BCD_W +: BCD_W], digit_limit(i, MODE),
                                              load, load_value[i*BCD_W +: BCD_W], inc[i], dec[i]);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lap_value <= '0;
      lap_valid <= 1'b0;
    end else if (clr) begin
      lap_valid <= 1'b0;
    end else if (lap) begin
      lap_value <= count_next;
      lap_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Randomised and directed bench for bcd_time_counter. Three instances share
// stimulus: A = decimal/wrap, B = sexagesimal/wrap, C = decimal/saturate.
// The reference model keeps each count as a plain integer in mixed radix.
module tb_bcd_time_counter;

  localparam int DIV = 10;
  localparam int ND  = 4;
  localparam int MODE_OF [3] = '{0, 1, 0};
  localparam int WRAP_OF [3] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        rstn, en, up, clr, load, lap;
  logic [15:0] load_value;
  logic [15:0] cnt [3];
  logic        tk [3], wr [3], le [3];
  logic [15:0] lapv [3];
  logic        lapok [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      bcd_time_counter #(
        .CLK_FREQ_HZ (10),
        .TICK_HZ     (1),
        .NUM_DIGITS  (ND),
        .MODE        (MODE_OF[k]),
        .WRAP        (WRAP_OF[k])
      ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .up         (up),
        .clr        (clr),
        .load       (load),
        .load_value (load_value),
        .count      (cnt[k]),
        .tick       (tk[k]),
        .wrap       (wr[k]),
        .load_err   (le[k])
`ifdef BCD_TIME_COUNTER_LAP_EN
        ,
        .lap        (lap),
        .lap_value  (lapv[k]),
        .lap_valid  (lapok[k])
`endif
      );
`ifndef BCD_TIME_COUNTER_LAP_EN
      assign lapv[k]  = 16'h0;
      assign lapok[k] = 1'b0;
`endif
    end
  endgenerate

  // ---------------- reference model ----------------
  int mpresc;
  bit mtick;
  int mval [3];
  bit mwrap [3], mlerr [3], mlapok [3];
  int mlapv [3];

  function automatic int radix(int i, int mode);
    return (mode == 1 && (i % 2) == 1) ? 6 : 10;
  endfunction

  function automatic int range_of(int mode);
    int r = 1;
    for (int i = 0; i < ND; i++) r *= radix(i, mode);
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(int v, int mode);
    logic [15:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(v % radix(i, mode));
      v = v / radix(i, mode);
    end
    return r;
  endfunction

  function automatic int from_bcd_clamped(logic [15:0] lv, int mode, output bit err);
    int v = 0, w = 1, d;
    err = 0;
    for (int i = 0; i < ND; i++) begin
      d = int'(lv[i*4 +: 4]);
      if (d > radix(i, mode) - 1) begin
        d = radix(i, mode) - 1;
        err = 1;
      end
      v += d * w;
      w *= radix(i, mode);
    end
    return v;
  endfunction

  task automatic model_step();
    bit t, e;
    int top;
    if (!rstn) begin
      mpresc = 0; mtick = 0;
      for (int k = 0; k < 3; k++) begin
        mval[k] = 0; mwrap[k] = 0; mlerr[k] = 0; mlapok[k] = 0; mlapv[k] = 0;
      end
    end else if (clr) begin
      mpresc = 0; mtick = 0;
      for (int k = 0; k < 3; k++) begin
        mval[k] = 0; mwrap[k] = 0; mlerr[k] = 0; mlapok[k] = 0;
      end
    end else begin
      t = en && (mpresc == DIV - 1);
      if (en) mpresc = t ? 0 : mpresc + 1;
      mtick = t;
      for (int k = 0; k < 3; k++) begin
        top = range_of(MODE_OF[k]) - 1;
        mwrap[k] = 0;
        mlerr[k] = 0;
        if (load) begin
          mval[k]  = from_bcd_clamped(load_value, MODE_OF[k], e);
          mlerr[k] = e;
        end else if (t) begin
          if (up) begin
            if (mval[k] < top) mval[k]++;
            else if (WRAP_OF[k] != 0) begin mval[k] = 0; mwrap[k] = 1; end
          end else begin
            if (mval[k] > 0) mval[k]--;
            else if (WRAP_OF[k] != 0) begin mval[k] = top; mwrap[k] = 1; end
          end
        end
        if (lap) begin
          mlapv[k]  = mval[k];
          mlapok[k] = 1;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("count[%0d]", k), 32'(cnt[k]), 32'(to_bcd(mval[k], MODE_OF[k])));
      chk($sformatf("tick[%0d]", k), 32'(tk[k]), 32'(mtick));
      chk($sformatf("wrap[%0d]", k), 32'(wr[k]), 32'(mwrap[k]));
      chk($sformatf("load_err[%0d]", k), 32'(le[k]), 32'(mlerr[k]));
`ifdef BCD_TIME_COUNTER_LAP_EN
      chk($sformatf("lap_valid[%0d]", k), 32'(lapok[k]), 32'(mlapok[k]));
      chk($sformatf("lap_value[%0d]", k), 32'(lapv[k]), 32'(to_bcd(mlapv[k], MODE_OF[k])));
`endif
    end
  endtask

  task automatic do_load(logic [15:0] v);
    load = 1'b1;
    load_value = v;
    cyc();
    load = 1'b0;
  endtask

  // Run until the model reports a tick; bounded by two prescaler periods.
  task automatic run_to_tick(string tag);
    bit got = 0;
    for (int i = 0; i < 2 * DIV && !got; i++) begin
      cyc();
      got = mtick;
    end
    if (!got) chk({tag, "_tick_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; en = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0; lap = 1'b0;
    load_value = '0;
    cyc(); cyc();
    chk("reset_count", 32'(cnt[0]), 32'h0);
    chk("reset_tick", 32'(tk[0]), 32'h0);

    // First update DIV enabled cycles after release
    rstn = 1'b1;
    repeat (9) cyc();
    chk("pre_first_tick_count", 32'(cnt[0]), 32'h0);
    cyc();
    chk("first_tick", 32'(tk[0]), 32'h1);
    chk("first_count", 32'(cnt[0]), 32'h0001);
    repeat (10) cyc();
    chk("second_count", 32'(cnt[0]), 32'h0002);
    en = 1'b0;
    repeat (5) cyc();
    en = 1'b1;
    repeat (9) cyc();
    chk("en_hold_no_tick", 32'(tk[0]), 32'h0);
    cyc();
    chk("en_hold_delayed_tick", 32'(tk[0]), 32'h1);

    // Carry chain and full wrap
    do_load(16'h0999); run_to_tick("c999");
    chk("carry_0999", 32'(cnt[0]), 32'h1000);
    do_load(16'h9999); run_to_tick("c9999");
    chk("wrap_9999_count", 32'(cnt[0]), 32'h0000);
    chk("wrap_9999_pulse", 32'(wr[0]), 32'h1);
    chk("sat_9999_hold", 32'(cnt[2]), 32'h9999);
    chk("sat_9999_nowrap", 32'(wr[2]), 32'h0);
    do_load(16'h0059); run_to_tick("c59");
    chk("sex_0059", 32'(cnt[1]), 32'h0100);
    do_load(16'h5959); run_to_tick("c5959");
    chk("sex_wrap_count", 32'(cnt[1]), 32'h0000);
    chk("sex_wrap_pulse", 32'(wr[1]), 32'h1);
    do_load(16'h0097);
    chk("sex_clamp", 32'(cnt[1]), 32'h0057);
    chk("sex_load_err", 32'(le[1]), 32'h1);
    chk("dec_no_load_err", 32'(le[0]), 32'h0);

    // Down counting
    up = 1'b0;
    do_load(16'h0000); run_to_tick("dn0");
    chk("down_wrap_count", 32'(cnt[0]), 32'h9999);
    chk("down_wrap_pulse", 32'(wr[0]), 32'h1);
    chk("down_sat_count", 32'(cnt[2]), 32'h0000);
    chk("down_sat_nowrap", 32'(wr[2]), 32'h0);
    do_load(16'h0000);
    for (int j = 0; j < 3; j++) begin
      run_to_tick("dnsat");
      chk("down_sat_tick", 32'(tk[2]), 32'h1);
      chk("down_sat_hold", 32'(cnt[2]), 32'h0000);
    end

    // Load on a tick cycle: load wins
    for (int i = 0; i < DIV && mpresc != DIV - 1; i++) cyc();
    do_load(16'h1234);
    chk("load_on_tick_count", 32'(cnt[0]), 32'h1234);
    chk("load_on_tick_tick", 32'(tk[0]), 32'h1);

    // clr beats load
    clr = 1'b1;
    do_load(16'h5555);
    clr = 1'b0;
    chk("clr_load_count", 32'(cnt[0]), 32'h0000);

    // Reset mid-interval discards the pending tick
    up = 1'b1;
    do_load(16'h0300);
    for (int i = 0; i < DIV && mpresc != 7; i++) cyc();
    rstn = 1'b0;
    cyc();
    chk("rst_mid_count", 32'(cnt[0]), 32'h0000);
    rstn = 1'b1;
    repeat (9) cyc();
    chk("rst_mid_no_tick", 32'(tk[0]), 32'h0);
    cyc();
    chk("rst_mid_full_interval", 32'(tk[0]), 32'h1);

`ifdef BCD_TIME_COUNTER_LAP_EN
    load = 1'b1; load_value = 16'h0042; lap = 1'b1;
    cyc();
    load = 1'b0; lap = 1'b0;
    chk("lap_value_42", 32'(lapv[0]), 32'h0042);
    chk("lap_valid_set", 32'(lapok[0]), 32'h1);
    repeat (15) cyc();
    chk("lap_hold", 32'(lapv[0]), 32'h0042);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("lap_valid_clr", 32'(lapok[0]), 32'h0);
`endif

    // Randomised phase
    for (int i = 0; i < 1500; i++) begin
      rstn = ($urandom_range(0, 199) != 0);
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) up = ~up;
      clr  = ($urandom_range(0, 79) == 0);
      load = ($urandom_range(0, 29) == 0);
      lap  = ($urandom_range(0, 19) == 0);
      load_value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) load_value = {4'h9, 4'h5, 4'h9, 4'h9};
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
